univ_shift_register: RTL
========================

UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have derived localparam CNT_W, value $clog2(WIDTH+1), burst-count width.
REQ-003 SHALL have port clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port mode_i  input  3  operation select: HOLD=0, LOAD=1, SHL=2, SHR=3, ROL=4, ROR=5, ASR=6, 7=reserved.
REQ-006 SHALL have port load_i  input  WIDTH  parallel load data.
REQ-007 SHALL have port sl_i  input  1  serial input entering the LSB on SHL.
REQ-008 SHALL have port sr_i  input  1  serial input entering the MSB on SHR.
REQ-009 SHALL have port start_i  input  1  burst-start request.
REQ-010 SHALL have port count_i  input  CNT_W  burst shift count.
REQ-011 SHALL have port q_o  output  WIDTH  register contents.
REQ-012 SHALL have port msb_o / lsb_o  output  1 each  q_o[WIDTH-1] / q_o[0], driven combinationally from the register.
REQ-013 SHALL have port busy_o  output  1  high while in SHIFT.
REQ-014 SHALL have port done_o  output  1  one-cycle burst-complete pulse.

Function
REQ-015 SHALL, in IDLE with start_i=0, apply mode_i every cycle:
- HOLD: q unchanged.
- LOAD: q=load_i.
- SHL: q={q[W-2:0],sl_i}.
- SHR: q={sr_i,q[W-1:1]}.
- ROL: q={q[W-2:0],q[W-1]}.
- ROR: q={q[0],q[W-1:1]}.
- ASR: q={q[W-1],q[W-1:1]}.
- 7: q unchanged.
REQ-016 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-017 SHALL accept start_i only in IDLE and only with mode_i in 2..6; otherwise start_i is ignored and REQ-015 applies.
REQ-018 SHALL, on the accepting edge: latch mode_i; latch min(count_i, WIDTH) into the remaining-count register; hold q; go to SHIFT, or to DONE if the count is 0.
REQ-019 SHALL, in SHIFT, perform one shift per edge using the latched mode and the live sl_i/sr_i, and decrement the remaining count.
REQ-020 SHALL go from SHIFT to DONE on the edge performing the last shift; for a start accepted at edge k with N>0, shifts occur at edges k+1..k+N.
REQ-021 SHALL assert done_o for exactly the one cycle spent in DONE, hold q during DONE, and then return to IDLE.
REQ-022 SHALL ignore mode_i, start_i, count_i and load_i while in SHIFT or DONE.
REQ-023 SHALL not assert busy_o in DONE, and SHALL never assert busy_o and done_o together.
REQ-024 SHALL generate all serial/rotate bit indices from WIDTH, with no hardcoded widths.

Reset
REQ-025 SHALL, while reset=1, force q_o=0, FSM=IDLE, remaining count=0, latched mode=HOLD, busy_o=0, done_o=0.
REQ-026 SHALL treat reset asserted mid-burst as an abort: the burst is discarded, no done_o pulse is produced, and operation restarts in IDLE on the first edge after release.

Structure
REQ-027 SHALL take the mode enum (usr_mode_t) and FSM enum (usr_state_t) from shared package usr_pkg.
REQ-028 SHALL place the FSM plus remaining-count counter in sub-module usr_burst_ctrl; the datapath next-value mux SHALL remain in univ_shift_register.

Verification (WIDTH=8)
REQ-029 SHALL cover: reset, then LOAD 0xA5, then SHL with sl_i=1 for 1 cycle -> q=0x4B.
REQ-030 SHALL cover: q=0x81, ROR for 1 cycle -> 0xC0; ROL for 2 cycles -> 0x03.
REQ-031 SHALL cover: q=0x90, ASR for 2 cycles -> 0xE4; q=0x90, SHR with sr_i=0 for 2 cycles -> 0x24.
REQ-032 SHALL cover: q=0x01, start with SHL, count=3, sl_i=0 ->
- busy_o high for exactly 3 cycles;
- q=0x08;
- done_o pulses 1 cycle;
- mode_i toggled during the burst has no effect.
REQ-033 SHALL cover: start with count=0 -> no busy_o, done_o pulses in the next cycle, q unchanged. Start with count=12 -> clamped to 8 shifts.
REQ-034 SHALL cover: reset asserted at the 2nd cycle of a count=5 burst -> q=0 immediately, no done_o; the IDLE LOAD works after release.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
// Latency: n/a (types and one helper function only).
// Backpressure: n/a.
package usr_pkg;

    // Operation select as presented on mode_i. Code 7 is reserved and behaves as HOLD.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } usr_mode_t;

    // Burst controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } usr_state_t;

    // Only the shift/rotate modes can run as a counted burst.
    function automatic logic is_burst_mode(input usr_mode_t m);
        logic ok;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: IDLE/SHIFT/DONE FSM with a clamped remaining-shift counter.
// Latency: accepts a start on the edge it is seen; N shifts follow on the next N edges, then one DONE cycle.
// Backpressure: none; start_i is simply ignored outside IDLE or with a non-shift mode.
//
// Ports: clk/reset (async, active-high); mode_i/start_i/count_i burst request;
// burst_mode_o latched mode; accept_o start taken this cycle; shift_o shift on this edge;
// idle_o in IDLE; busy_o in SHIFT; done_o in DONE.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  usr_mode_t        mode_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    output usr_mode_t        burst_mode_o,
    output logic             accept_o,
    output logic             shift_o,
    output logic             idle_o,
    output logic             busy_o,
    output logic             done_o
);

    usr_state_t       state_q, state_d;
    usr_mode_t        mode_q,  mode_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] cnt_clamped;

    // A register can be shifted at most WIDTH times before its contents are fully replaced.
    assign cnt_clamped = (count_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count_i;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && is_burst_mode(mode_i)) begin
                    accept_o = 1'b1;
                    mode_d   = mode_i;
                    cnt_d    = cnt_clamped;
                    // A zero-length burst still reports completion.
                    state_d  = (cnt_clamped == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign burst_mode_o = mode_q;
    assign shift_o      = (state_q == ST_SHIFT);
    assign idle_o       = (state_q == ST_IDLE);
    assign busy_o       = (state_q == ST_SHIFT);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register: hold/load/shift/rotate/arith-shift per cycle, plus counted shift bursts.
// Latency: register updates on each rising edge; a burst of N shifts completes N+1 edges after acceptance.
// Backpressure: none; inputs other than sl_i/sr_i are ignored while a burst is busy or done.
//
// Ports: clk/reset (async, active-high); mode_i op select; load_i parallel data;
// sl_i/sr_i serial inputs; start_i/count_i burst request; q_o contents;
// msb_o/lsb_o end bits; busy_o burst shifting; done_o one-cycle burst-complete pulse.
module univ_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] load_i,
    input  logic             sl_i,
    input  logic             sr_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [WIDTH-1:0] q_o,
    output logic             msb_o,
    output logic             lsb_o,
    output logic             busy_o,
    output logic             done_o
);

    usr_mode_t        mode_in;
    usr_mode_t        burst_mode;
    usr_mode_t        eff_mode;
    logic             accept;
    logic             shift_en;
    logic             idle;
    logic [WIDTH-1:0] q_q, q_d;

    assign mode_in = usr_mode_t'(mode_i);

    usr_burst_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .mode_i       (mode_in),
        .start_i      (start_i),
        .count_i      (count_i),
        .burst_mode_o (burst_mode),
        .accept_o     (accept),
        .shift_o      (shift_en),
        .idle_o       (idle),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Bursts run on the latched mode; the accepting edge and the DONE cycle hold q.
    always_comb begin
        eff_mode = MODE_HOLD;
        if (shift_en) begin
            eff_mode = burst_mode;
        end else if (idle && !accept) begin
            eff_mode = mode_in;
        end
    end

    always_comb begin
        q_d = q_q;
        case (eff_mode)
            MODE_LOAD: q_d = load_i;
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], sl_i};
            MODE_SHR:  q_d = {sr_i, q_q[WIDTH-1:1]};
            MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign msb_o = q_q[WIDTH-1];
    assign lsb_o = q_q[0];

endmodule
